ps2_key_sequencer: RTL and testbench
====================================

# ps2_key_sequencer

Sits between the PS/2 byte receiver and the key decoder. It parses the raw scancode byte stream (set 2), strips the E0/F0/E1 prefixes and drops keyboard status bytes. It issues one-cycle make/break strobes with the base code, and filters auto-repeat on the ten game keys so the decoder's write enables fire once per physical press.

## Interface
- D_WIDTH, 8, scancode byte width
- TIMEOUT_CYCLES, 50000, idle cycles allowed inside a prefix sequence before abort (1 ms at 50 MHz)
- REPEAT_FILTER, 1, 1 = suppress repeated makes of held tracked keys; 0 = pass all makes

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  D_WIDTH  byte from PS/2 receiver, valid only with rx_valid
- rx_valid  in  1  one-cycle strobe, byte accepted that cycle
- key_code  out  D_WIDTH  registered base code of last emitted event; holds between events
- en  out  1  one-cycle make strobe for non-extended keys (drives decoder en)
- brk  out  1  one-cycle break strobe for non-extended keys
- ext  out  1  one-cycle strobe: an extended (E0) make or break was consumed
- held  out  10  held mask, bit order {kp6,kp5,kp4,enter,space,d,s,a,w,e} = codes {74,73,6B,5A,29,23,1B,1C,1D,24}
- err  out  1  one-cycle strobe on timeout, illegal prefix order or keyboard error byte

## Operation
- States: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP.
- Byte handling in IDLE:
  - E0 → GOT_E0.
  - F0 → GOT_F0.
  - E1 → SKIP with skip count 7.
  - AA/FA/EE dropped, no strobe.
  - 00/FF/FC → err; held cleared.
  - Any other byte is a make.
- Make: key_code←byte.
  - en=1 unless REPEAT_FILTER=1 and the byte is tracked with its held bit set.
  - A tracked byte sets its held bit.
  - Untracked bytes always strobe en and have no held state.
- GOT_F0:
  - A non-prefix byte is a break: key_code←byte, brk=1, held bit cleared, → IDLE.
  - E0, F0 or E1 → err, → IDLE.
- GOT_E0:
  - F0 → GOT_E0F0.
  - E0 → stay.
  - Any other byte → ext=1, key_code←byte, → IDLE. en stays 0 and held is untouched, so arrow keys sharing codes 6B/74 never alias keypad keys.
- GOT_E0F0:
  - A non-prefix byte → ext=1, key_code←byte, → IDLE.
  - A prefix byte → err, → IDLE.
- SKIP: each accepted byte decrements the count; → IDLE after the 7th. No strobes. Covers the Pause sequence.
- Timeout:
  - The counter runs in every non-IDLE state and clears on each accepted byte.
  - At TIMEOUT_CYCLES idle cycles: → IDLE, err=1.
- At most one of en/brk/ext/err is high in any cycle.

## Timing
- Reset values: state IDLE, key_code 0, en/brk/ext/err 0, held 0, counters 0.
- Latency: byte accepted at edge N → strobe and key_code valid after edge N, so high during cycle N+1 only.
- held updates on the same edge as the strobe.
- rx_valid back-to-back every cycle is supported with no stalls.
- If rx_valid coincides with timeout expiry, the byte wins: it is processed normally, with no err.
- Reset mid-sequence discards any partial prefix and the SKIP count.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.

## Structure
- Shared package ps2_pkg holds:
  - Scancode constants E0, F0, E1, AA, FA, EE, 00, FF, FC.
  - The ten tracked codes and their held-bit index mapping, shared with the decoder.
  - The state enum.
- Sub-module ps2_held_tracker holds the held register and the code-to-index match.
  - Inputs: code, set, clr, clear_all.
  - Outputs: hit, held.

## Test plan
- Stream 1D,1D,1D,F0,1D → en once at the first 1D; held[1] 1 then 0; brk once with key_code=1D.
- Stream E0,6B then E0,F0,6B → two ext strobes, en/brk never high, held[7] stays 0; then 6B → en=1, held[7]=1.
- E0 followed by 50000 idle cycles → err pulse on expiry, state IDLE; next byte 24 → en with key_code=24.
- E1,14,77,E1,F0,14,F0,77 then 1C → no strobes for the first 8 bytes, then en with key_code=1C.
- Hold 24 and 23, then send FF → err, held=0; then 24 → en (not filtered).
- rst asserted during GOT_F0 with held=0x3FF → all outputs 0 next cycle; then 24 → en, not brk.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 scancode path (set 2).
//   - Prefix, status and error byte constants seen on the raw byte stream.
//   - The ten tracked game keys and their bit position in the held mask.
//     The decoder uses the same mapping, so keep both in sync via this file.
//   - The prefix-parser state enum.
// No ports; imported with "import ps2_pkg::*".

package ps2_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;

    // Keyboard status bytes: self-test passed, ACK, echo
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_EE = 8'hEE;

    // Keyboard error / overrun bytes
    localparam logic [7:0] SC_00 = 8'h00;
    localparam logic [7:0] SC_FF = 8'hFF;
    localparam logic [7:0] SC_FC = 8'hFC;

    // The Pause key sends E1 followed by seven more bytes
    localparam logic [2:0] SKIP_LEN = 3'd7;

    localparam int NUM_TRACKED = 10;

    // Held-mask bit order {kp6,kp5,kp4,enter,space,d,s,a,w,e}
    localparam int IDX_E     = 0;
    localparam int IDX_W     = 1;
    localparam int IDX_A     = 2;
    localparam int IDX_S     = 3;
    localparam int IDX_D     = 4;
    localparam int IDX_SPACE = 5;
    localparam int IDX_ENTER = 6;
    localparam int IDX_KP4   = 7;
    localparam int IDX_KP5   = 8;
    localparam int IDX_KP6   = 9;

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        SKIP
    } ps2_state_t;

    // Maps a base code to a one-hot held-mask position; zero for untracked codes.
    function automatic logic [NUM_TRACKED-1:0] tracked_onehot(input logic [7:0] code);
        logic [NUM_TRACKED-1:0] oh;
        oh = '0;
        case (code)
            8'h24: oh[IDX_E]     = 1'b1;
            8'h1D: oh[IDX_W]     = 1'b1;
            8'h1C: oh[IDX_A]     = 1'b1;
            8'h1B: oh[IDX_S]     = 1'b1;
            8'h23: oh[IDX_D]     = 1'b1;
            8'h29: oh[IDX_SPACE] = 1'b1;
            8'h5A: oh[IDX_ENTER] = 1'b1;
            8'h6B: oh[IDX_KP4]   = 1'b1;
            8'h73: oh[IDX_KP5]   = 1'b1;
            8'h74: oh[IDX_KP6]   = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/ps2_held_tracker.sv
// ps2_held_tracker
// Keeps one "held" bit per tracked game key and reports whether the byte
// currently on the bus is a tracked key that is already held.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   code       - base scancode presented this cycle
//   set        - make accepted: set the bit for code (no effect if untracked)
//   clr        - break accepted: clear the bit for code
//   clear_all  - keyboard error seen: drop every held bit
//   hit        - code is tracked and its held bit is currently set
//   held       - held mask, bit order as in ps2_pkg

module ps2_held_tracker
    import ps2_pkg::*;
#(
    parameter int D_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [D_WIDTH-1:0]     code,
    input  logic                   set,
    input  logic                   clr,
    input  logic                   clear_all,
    output logic                   hit,
    output logic [NUM_TRACKED-1:0] held
);

    logic [NUM_TRACKED-1:0] match;

    // Tracked codes all fit in the low byte of the scancode.
    assign match = tracked_onehot(8'(code));
    assign hit   = |(match & held);

    // Held register: an error byte wipes everything since the keyboard
    // state can no longer be trusted; otherwise a make sets and a break
    // clears the single bit selected by the code.
    always_ff @(posedge clk) begin
        if (rst) begin
            held <= '0;
        end else if (clear_all) begin
            held <= '0;
        end else if (set) begin
            held <= held | match;
        end else if (clr) begin
            held <= held & ~match;
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
// Parses the raw PS/2 set-2 byte stream, strips E0/F0/E1 prefixes, drops
// status bytes and issues one-cycle make/break/extended/error strobes with
// the base code. Repeated makes of held game keys can be filtered so the
// decoder sees one en per physical press.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   rx_data   - byte from the PS/2 receiver, valid with rx_valid
//   rx_valid  - one-cycle strobe, byte accepted that cycle
//   key_code  - base code of the last emitted event, holds between events
//   en        - make strobe, non-extended keys
//   brk       - break strobe, non-extended keys
//   ext       - extended (E0) make or break consumed
//   held      - held mask of the ten tracked keys
//   err       - timeout, illegal prefix order or keyboard error byte

module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int D_WIDTH        = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit REPEAT_FILTER  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [D_WIDTH-1:0]     rx_data,
    input  logic                   rx_valid,
    output logic [D_WIDTH-1:0]     key_code,
    output logic                   en,
    output logic                   brk,
    output logic                   ext,
    output logic [NUM_TRACKED-1:0] held,
    output logic                   err
);

    localparam int             TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]  TIMER_MAX  = TW'(TIMEOUT_CYCLES);

    ps2_state_t         state, state_n;
    logic [2:0]         skip_cnt, skip_n;
    logic [TW-1:0]      timer, timer_n;
    logic [D_WIDTH-1:0] key_code_n;
    logic               en_n, brk_n, ext_n, err_n;
    logic               timeout;

    logic               trk_set, trk_clr, trk_clear_all, trk_hit;

    logic is_e0, is_f0, is_e1, is_prefix, is_status, is_kbd_err;

    assign is_e0      = (rx_data == D_WIDTH'(SC_E0));
    assign is_f0      = (rx_data == D_WIDTH'(SC_F0));
    assign is_e1      = (rx_data == D_WIDTH'(SC_E1));
    assign is_prefix  = is_e0 | is_f0 | is_e1;
    assign is_status  = (rx_data == D_WIDTH'(SC_AA)) | (rx_data == D_WIDTH'(SC_FA)) |
                        (rx_data == D_WIDTH'(SC_EE));
    assign is_kbd_err = (rx_data == D_WIDTH'(SC_00)) | (rx_data == D_WIDTH'(SC_FF)) |
                        (rx_data == D_WIDTH'(SC_FC));

    ps2_held_tracker #(
        .D_WIDTH (D_WIDTH)
    ) u_held_tracker (
        .clk       (clk),
        .rst       (rst),
        .code      (rx_data),
        .set       (trk_set),
        .clr       (trk_clr),
        .clear_all (trk_clear_all),
        .hit       (trk_hit),
        .held      (held)
    );

    // State, counters and the registered strobes/key code. All strobes are
    // computed combinationally from the accepted byte and registered here,
    // so they are high for exactly the cycle after the byte is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            skip_cnt <= '0;
            timer    <= '0;
            key_code <= '0;
            en       <= 1'b0;
            brk      <= 1'b0;
            ext      <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_n;
            timer    <= timer_n;
            key_code <= key_code_n;
            en       <= en_n;
            brk      <= brk_n;
            ext      <= ext_n;
            err      <= err_n;
        end
    end

    // Next-state and strobe logic. A byte arriving on the expiry cycle is
    // processed normally (timeout requires !rx_valid), and each path raises
    // at most one strobe so en/brk/ext/err stay mutually exclusive.
    always_comb begin
        state_n       = state;
        skip_n        = skip_cnt;
        key_code_n    = key_code;
        en_n          = 1'b0;
        brk_n         = 1'b0;
        ext_n         = 1'b0;
        err_n         = 1'b0;
        trk_set       = 1'b0;
        trk_clr       = 1'b0;
        trk_clear_all = 1'b0;
        timer_n       = timer;
        timeout       = (state != IDLE) && !rx_valid && (timer == TIMER_LAST);

        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (is_e0) begin
                        state_n = GOT_E0;
                    end else if (is_f0) begin
                        state_n = GOT_F0;
                    end else if (is_e1) begin
                        state_n = SKIP;
                        skip_n  = SKIP_LEN;
                    end else if (is_status) begin
                        state_n = IDLE;
                    end else if (is_kbd_err) begin
                        err_n         = 1'b1;
                        trk_clear_all = 1'b1;
                    end else begin
                        key_code_n = rx_data;
                        en_n       = !(REPEAT_FILTER && trk_hit);
                        trk_set    = 1'b1;
                    end
                end
                GOT_F0: begin
                    state_n = IDLE;
                    if (is_prefix) begin
                        err_n = 1'b1;
                    end else begin
                        key_code_n = rx_data;
                        brk_n      = 1'b1;
                        trk_clr    = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (is_f0) begin
                        state_n = GOT_E0F0;
                    end else if (is_e0) begin
                        state_n = GOT_E0;
                    end else begin
                        // Extended keys never touch held, so arrows sharing
                        // 6B/74 cannot alias the keypad keys.
                        state_n    = IDLE;
                        ext_n      = 1'b1;
                        key_code_n = rx_data;
                    end
                end
                GOT_E0F0: begin
                    state_n = IDLE;
                    if (is_prefix) begin
                        err_n = 1'b1;
                    end else begin
                        ext_n      = 1'b1;
                        key_code_n = rx_data;
                    end
                end
                SKIP: begin
                    if (skip_cnt <= 3'd1) begin
                        state_n = IDLE;
                        skip_n  = '0;
                    end else begin
                        skip_n = skip_cnt - 3'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    skip_n  = '0;
                end
            endcase
        end else if (timeout) begin
            state_n = IDLE;
            skip_n  = '0;
            err_n   = 1'b1;
        end

        // Idle-cycle counter: only runs while inside a sequence, restarts on
        // every accepted byte and saturates rather than wrapping.
        if (rx_valid || (state == IDLE) || timeout) begin
            timer_n = '0;
        end else if (timer != TIMER_MAX) begin
            timer_n = timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer
// Directed bench for ps2_key_sequencer with hand-computed expected values.
// Each scenario task drives a byte sequence and compares the strobes
// {en,brk,ext,err}, key_code and held mask after every step.

module tb_ps2_key_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] key_code;
    logic       en;
    logic       brk;
    logic       ext;
    logic [9:0] held;
    logic       err;

    int checks;
    int failures;

    // One step: v=1 sends byte b, v=0 leaves the bus idle for a cycle.
    // s = expected {en,brk,ext,err}, kc = expected key_code, h = held mask.
    typedef struct {
        bit         v;
        logic [7:0] b;
        logic [3:0] s;
        logic [7:0] kc;
        logic [9:0] h;
    } vec_t;

    ps2_key_sequencer #(
        .D_WIDTH        (8),
        .TIMEOUT_CYCLES (50000),
        .REPEAT_FILTER  (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .key_code (key_code),
        .en       (en),
        .brk      (brk),
        .ext      (ext),
        .held     (held),
        .err      (err)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobes must never overlap; checked on every falling edge.
    always @(negedge clk) begin
        checks++;
        if (!$onehot0({en, brk, ext, err})) begin
            failures++;
            $display("[TB] FAIL strobe_exclusive got {en,brk,ext,err}=%b required at most one high",
                     {en, brk, ext, err});
        end
    end

    // Presents one byte for exactly one rising edge, then samples 1 ns later.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({en, brk, ext, err, key_code, held} !== 22'h0) begin
            failures++;
            $display("[TB] FAIL reset got s=%b kc=%h held=%h required all zero",
                     {en, brk, ext, err}, key_code, held);
        end
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_repeat_filter();
        vec_t v [8] = '{
            '{1'b1, 8'h1D, 4'b1000, 8'h1D, 10'h002},
            '{1'b1, 8'h1D, 4'b0000, 8'h1D, 10'h002},
            '{1'b1, 8'h1D, 4'b0000, 8'h1D, 10'h002},
            '{1'b1, 8'hF0, 4'b0000, 8'h1D, 10'h002},
            '{1'b1, 8'h1D, 4'b0100, 8'h1D, 10'h000},
            '{1'b0, 8'h00, 4'b0000, 8'h1D, 10'h000},
            '{1'b1, 8'h15, 4'b1000, 8'h15, 10'h000},
            '{1'b1, 8'h15, 4'b1000, 8'h15, 10'h000}
        };
        foreach (v[i]) begin
            if (v[i].v) applyStimulus(v[i].b); else idle_cycle();
            checks++;
            if ({en, brk, ext, err, key_code, held} !== {v[i].s, v[i].kc, v[i].h}) begin
                failures++;
                $display("[TB] FAIL repeat[%0d] got s=%b kc=%h held=%h required s=%b kc=%h held=%h",
                         i, {en, brk, ext, err}, key_code, held, v[i].s, v[i].kc, v[i].h);
            end
        end
    endtask

    task automatic test_extended();
        vec_t v [12] = '{
            '{1'b1, 8'hE0, 4'b0000, 8'h15, 10'h000},
            '{1'b1, 8'h6B, 4'b0010, 8'h6B, 10'h000},
            '{1'b1, 8'hE0, 4'b0000, 8'h6B, 10'h000},
            '{1'b1, 8'hF0, 4'b0000, 8'h6B, 10'h000},
            '{1'b1, 8'h6B, 4'b0010, 8'h6B, 10'h000},
            '{1'b1, 8'h6B, 4'b1000, 8'h6B, 10'h080},
            '{1'b1, 8'h6B, 4'b0000, 8'h6B, 10'h080},
            '{1'b1, 8'hF0, 4'b0000, 8'h6B, 10'h080},
            '{1'b1, 8'h6B, 4'b0100, 8'h6B, 10'h000},
            '{1'b1, 8'hE0, 4'b0000, 8'h6B, 10'h000},
            '{1'b1, 8'hE0, 4'b0000, 8'h6B, 10'h000},
            '{1'b1, 8'h75, 4'b0010, 8'h75, 10'h000}
        };
        foreach (v[i]) begin
            if (v[i].v) applyStimulus(v[i].b); else idle_cycle();
            checks++;
            if ({en, brk, ext, err, key_code, held} !== {v[i].s, v[i].kc, v[i].h}) begin
                failures++;
                $display("[TB] FAIL extended[%0d] got s=%b kc=%h held=%h required s=%b kc=%h held=%h",
                         i, {en, brk, ext, err}, key_code, held, v[i].s, v[i].kc, v[i].h);
            end
        end
    endtask

    task automatic test_timeout();
        int   wait_cycles;
        bit   seen;
        vec_t v [4] = '{
            '{1'b0, 8'h00, 4'b0000, 8'h75, 10'h000},
            '{1'b1, 8'h24, 4'b1000, 8'h24, 10'h001},
            '{1'b1, 8'hF0, 4'b0000, 8'h24, 10'h001},
            '{1'b1, 8'h24, 4'b0100, 8'h24, 10'h000}
        };
        wait_cycles = 0;
        seen        = 1'b0;
        applyStimulus(8'hE0);
        while (!seen && wait_cycles < 60000) begin
            idle_cycle();
            wait_cycles++;
            if (err === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || wait_cycles != 50000) begin
            failures++;
            $display("[TB] FAIL timeout_cycles got seen=%0b cycles=%0d required seen=1 cycles=50000",
                     seen, wait_cycles);
        end
        checks++;
        if ({en, brk, ext, err, key_code} !== {4'b0001, 8'h75}) begin
            failures++;
            $display("[TB] FAIL timeout_strobe got s=%b kc=%h required s=0001 kc=75",
                     {en, brk, ext, err}, key_code);
        end
        foreach (v[i]) begin
            if (v[i].v) applyStimulus(v[i].b); else idle_cycle();
            checks++;
            if ({en, brk, ext, err, key_code, held} !== {v[i].s, v[i].kc, v[i].h}) begin
                failures++;
                $display("[TB] FAIL timeout[%0d] got s=%b kc=%h held=%h required s=%b kc=%h held=%h",
                         i, {en, brk, ext, err}, key_code, held, v[i].s, v[i].kc, v[i].h);
            end
        end
    endtask

    task automatic test_pause_skip();
        vec_t v [11] = '{
            '{1'b1, 8'hE1, 4'b0000, 8'h24, 10'h000},
            '{1'b1, 8'h14, 4'b0000, 8'h24, 10'h000},
            '{1'b1, 8'h77, 4'b0000, 8'h24, 10'h000},
            '{1'b1, 8'hE1, 4'b0000, 8'h24, 10'h000},
            '{1'b1, 8'hF0, 4'b0000, 8'h24, 10'h000},
            '{1'b1, 8'h14, 4'b0000, 8'h24, 10'h000},
            '{1'b1, 8'hF0, 4'b0000, 8'h24, 10'h000},
            '{1'b1, 8'h77, 4'b0000, 8'h24, 10'h000},
            '{1'b1, 8'h1C, 4'b1000, 8'h1C, 10'h004},
            '{1'b1, 8'hF0, 4'b0000, 8'h1C, 10'h004},
            '{1'b1, 8'h1C, 4'b0100, 8'h1C, 10'h000}
        };
        foreach (v[i]) begin
            if (v[i].v) applyStimulus(v[i].b); else idle_cycle();
            checks++;
            if ({en, brk, ext, err, key_code, held} !== {v[i].s, v[i].kc, v[i].h}) begin
                failures++;
                $display("[TB] FAIL pause[%0d] got s=%b kc=%h held=%h required s=%b kc=%h held=%h",
                         i, {en, brk, ext, err}, key_code, held, v[i].s, v[i].kc, v[i].h);
            end
        end
    endtask

    task automatic test_error_bytes();
        vec_t v [15] = '{
            '{1'b1, 8'h24, 4'b1000, 8'h24, 10'h001},
            '{1'b1, 8'h23, 4'b1000, 8'h23, 10'h011},
            '{1'b1, 8'h24, 4'b0000, 8'h24, 10'h011},
            '{1'b1, 8'hFF, 4'b0001, 8'h24, 10'h000},
            '{1'b1, 8'h24, 4'b1000, 8'h24, 10'h001},
            '{1'b1, 8'hAA, 4'b0000, 8'h24, 10'h001},
            '{1'b1, 8'hFA, 4'b0000, 8'h24, 10'h001},
            '{1'b1, 8'hF0, 4'b0000, 8'h24, 10'h001},
            '{1'b1, 8'hE0, 4'b0001, 8'h24, 10'h001},
            '{1'b1, 8'hE0, 4'b0000, 8'h24, 10'h001},
            '{1'b1, 8'hF0, 4'b0000, 8'h24, 10'h001},
            '{1'b1, 8'hF0, 4'b0001, 8'h24, 10'h001},
            '{1'b1, 8'hF0, 4'b0000, 8'h24, 10'h001},
            '{1'b1, 8'h24, 4'b0100, 8'h24, 10'h000},
            '{1'b1, 8'hFC, 4'b0001, 8'h24, 10'h000}
        };
        foreach (v[i]) begin
            if (v[i].v) applyStimulus(v[i].b); else idle_cycle();
            checks++;
            if ({en, brk, ext, err, key_code, held} !== {v[i].s, v[i].kc, v[i].h}) begin
                failures++;
                $display("[TB] FAIL errbyte[%0d] got s=%b kc=%h held=%h required s=%b kc=%h held=%h",
                         i, {en, brk, ext, err}, key_code, held, v[i].s, v[i].kc, v[i].h);
            end
        end
    endtask

    task automatic test_reset_mid_sequence();
        vec_t v [11] = '{
            '{1'b1, 8'h24, 4'b1000, 8'h24, 10'h001},
            '{1'b1, 8'h1D, 4'b1000, 8'h1D, 10'h003},
            '{1'b1, 8'h1C, 4'b1000, 8'h1C, 10'h007},
            '{1'b1, 8'h1B, 4'b1000, 8'h1B, 10'h00F},
            '{1'b1, 8'h23, 4'b1000, 8'h23, 10'h01F},
            '{1'b1, 8'h29, 4'b1000, 8'h29, 10'h03F},
            '{1'b1, 8'h5A, 4'b1000, 8'h5A, 10'h07F},
            '{1'b1, 8'h6B, 4'b1000, 8'h6B, 10'h0FF},
            '{1'b1, 8'h73, 4'b1000, 8'h73, 10'h1FF},
            '{1'b1, 8'h74, 4'b1000, 8'h74, 10'h3FF},
            '{1'b1, 8'hF0, 4'b0000, 8'h74, 10'h3FF}
        };
        foreach (v[i]) begin
            if (v[i].v) applyStimulus(v[i].b); else idle_cycle();
            checks++;
            if ({en, brk, ext, err, key_code, held} !== {v[i].s, v[i].kc, v[i].h}) begin
                failures++;
                $display("[TB] FAIL rstmid[%0d] got s=%b kc=%h held=%h required s=%b kc=%h held=%h",
                         i, {en, brk, ext, err}, key_code, held, v[i].s, v[i].kc, v[i].h);
            end
        end
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        checks++;
        if ({en, brk, ext, err, key_code, held} !== 22'h0) begin
            failures++;
            $display("[TB] FAIL rstmid_clear got s=%b kc=%h held=%h required all zero",
                     {en, brk, ext, err}, key_code, held);
        end
        applyStimulus(8'h24);
        checks++;
        if ({en, brk, ext, err, key_code, held} !== {4'b1000, 8'h24, 10'h001}) begin
            failures++;
            $display("[TB] FAIL rstmid_after got s=%b kc=%h held=%h required s=1000 kc=24 held=001",
                     {en, brk, ext, err}, key_code, held);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_repeat_filter();
        test_extended();
        test_timeout();
        test_pause_skip();
        test_error_bytes();
        test_reset_mid_sequence();
        idle_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
